// File: rtl/frankie_mem_arbiter_if.sv
// Bus bundle for frankie_mem_arbiter: CPU port, loader/debug port and the
// single-port synchronous memory port.
//   master : environment side (drives requests and mem_rdata)
//   slave  : arbiter side (drives acks, read data, stall and the memory strobe)
// ADDR_W / DATA_W must match the parameters of the arbiter instance.
interface frankie_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/frankie_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// CPU has priority; the loader is forced through after MAX_GRANT consecutive
// CPU grants made while it was waiting. One access per two cycles:
// IDLE/RESP (arbitrate) -> ISSUE (mem_en strobe) -> RESP (ack to owner).
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset
//   bus   : frankie_mem_arbiter_if.slave (CPU, loader and memory signals)
module frankie_mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_GRANT = 8
) (
  input logic                 clock,
  input logic                 reset,
  frankie_mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (MAX_GRANT < 1) ? 1 : $clog2(MAX_GRANT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_GRANT);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = loader owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic cpu_wins;
  logic resp_cpu, resp_ldr;

  // Loader only wins a contested edge once the CPU has used its full quota.
  assign cpu_wins = bus.cpu_req & ~(bus.ldr_req & (starve_q == CntMax));

  assign resp_cpu = (state_q == StResp) & ~owner_q;
  assign resp_ldr = (state_q == StResp) & owner_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    unique case (state_q)
      StIssue: state_d = StResp;
      StIdle, StResp: begin
        // Memory data is valid during the ack cycle; keep it for later cycles.
        if (resp_cpu && !we_q) cpu_rdata_d = bus.mem_rdata;
        if (resp_ldr && !we_q) ldr_rdata_d = bus.mem_rdata;

        state_d = StIdle;
        if (cpu_wins) begin
          state_d  = StIssue;
          owner_d  = 1'b0;
          we_d     = bus.cpu_we;
          addr_d   = bus.cpu_addr;
          wdata_d  = bus.cpu_wdata;
          if (bus.ldr_req) begin
            starve_d = (starve_q == CntMax) ? starve_q : starve_q + CntW'(1);
          end else begin
            starve_d = '0;
          end
        end else if (bus.ldr_req) begin
          state_d  = StIssue;
          owner_d  = 1'b1;
          we_d     = bus.ldr_we;
          addr_d   = bus.ldr_addr;
          wdata_d  = bus.ldr_wdata;
          starve_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_we    = (state_q == StIssue) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_ack   = resp_cpu;
  assign bus.ldr_ack   = resp_ldr;
  // Read data is forwarded straight from memory in the ack cycle, then held.
  assign bus.cpu_rdata = (resp_cpu && !we_q) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.ldr_rdata = (resp_ldr && !we_q) ? bus.mem_rdata : ldr_rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~resp_cpu;

endmodule

// File: tb/tb_frankie_mem_arbiter.sv
module tb_frankie_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MG = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  frankie_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frankie_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_GRANT(MG)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 16) return 16'hBEEF;
    return DW'((i * 40503) ^ 23130);
  endfunction

  // Synchronous single-port memory fixture: data appears the cycle after mem_en.
  logic [DW-1:0] fmem [256];
  bit            fmem_ready = 1'b0;
  always @(posedge clock) begin
    if (!fmem_ready) begin
      for (int i = 0; i < 256; i++) fmem[i] <= init_val(i);
      fmem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) fmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= fmem[bus.mem_addr[7:0]];
    end
  end

  // Transaction-level reference: shadow memory, quota counter and the
  // grant -> strobe next cycle -> ack the cycle after timing.
  logic [DW-1:0] shadow [256];
  bit            in_flight, fl_ldr, fl_we;
  logic [DW-1:0] fl_data;
  int            streak;
  bit            exp_en, exp_we, exp_cpu_ack, exp_ldr_ack;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_cpu_rdata, exp_ldr_rdata;
  bit            acks_seen [$];
  int            en_cnt;

  task automatic model_reset();
    in_flight = 0; streak = 0;
    exp_en = 0; exp_we = 0; exp_cpu_ack = 0; exp_ldr_ack = 0;
    exp_addr = '0; exp_wdata = '0; exp_cpu_rdata = '0; exp_ldr_rdata = '0;
  endtask

  task automatic model_edge();
    bit            take_ldr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            we;
    exp_en = 0; exp_we = 0; exp_cpu_ack = 0; exp_ldr_ack = 0;
    if (in_flight) begin
      in_flight = 0;
      if (fl_ldr) begin
        exp_ldr_ack = 1;
        if (!fl_we) exp_ldr_rdata = fl_data;
      end else begin
        exp_cpu_ack = 1;
        if (!fl_we) exp_cpu_rdata = fl_data;
      end
    end else if (bus.cpu_req || bus.ldr_req) begin
      take_ldr = bus.ldr_req && (!bus.cpu_req || streak == MG);
      if (take_ldr) begin
        streak = 0; a = bus.ldr_addr; d = bus.ldr_wdata; we = bus.ldr_we;
      end else begin
        streak = bus.ldr_req ? ((streak < MG) ? streak + 1 : MG) : 0;
        a = bus.cpu_addr; d = bus.cpu_wdata; we = bus.cpu_we;
      end
      in_flight = 1; fl_ldr = take_ldr; fl_we = we;
      exp_en = 1; exp_we = we; exp_addr = a; exp_wdata = d;
      if (we) shadow[a[7:0]] = d;
      else    fl_data = shadow[a[7:0]];
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_en",    32'(bus.mem_en),    32'(exp_en));
    chk("mem_we",    32'(bus.mem_we),    32'(exp_we));
    chk("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
    chk("cpu_ack",   32'(bus.cpu_ack),   32'(exp_cpu_ack));
    chk("ldr_ack",   32'(bus.ldr_ack),   32'(exp_ldr_ack));
    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rdata));
    chk("ldr_rdata", 32'(bus.ldr_rdata), 32'(exp_ldr_rdata));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~exp_cpu_ack));
    chk("dual_ack",  32'(bus.cpu_ack & bus.ldr_ack), 32'(0));
  endtask

  // Inputs stay stable from one falling edge to the next, so evaluating the
  // model at the falling edge sees what the DUT sampled at the rising edge.
  task automatic tick();
    @(negedge clock);
    if (!reset) model_edge();
    check_outputs();
    if (bus.cpu_ack || bus.ldr_ack) acks_seen.push_back(bus.ldr_ack);
    if (bus.mem_en) en_cnt++;
  endtask

  task automatic cpu_issue(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic ldr_issue(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!bus.cpu_req && !bus.ldr_req && !in_flight) break;
      tick();
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
      if (bus.ldr_ack) bus.ldr_req = 1'b0;
    end
    tick();
  endtask

  initial begin
    int k;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    model_reset();
    en_cnt = 0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();

    // CPU read of 0x0010
    cpu_issue(1'b0, 16'h0010, '0);
    tick();
    chk("r22_en", 32'(bus.mem_en), 32'd1);
    chk("r22_stall", 32'(bus.cpu_stall), 32'd1);
    tick();
    chk("r22_ack", 32'(bus.cpu_ack), 32'd1);
    chk("r22_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
    bus.cpu_req = 1'b0;
    tick();

    // Loader write then CPU read-back
    ldr_issue(1'b1, 16'h0020, 16'h1234);
    tick();
    chk("r23_we", 32'(bus.mem_we), 32'd1);
    tick();
    chk("r23_ldr_ack", 32'(bus.ldr_ack), 32'd1);
    bus.ldr_req = 1'b0;
    cpu_issue(1'b0, 16'h0020, '0);
    tick(); tick();
    chk("r23_rdata", 32'(bus.cpu_rdata), 32'h1234);
    chk("r23_ldr_rdata", 32'(bus.ldr_rdata), 32'h0);
    bus.cpu_req = 1'b0;
    tick();

    // Four back-to-back CPU reads
    k = 0;
    cpu_issue(1'b0, 16'h0000, '0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cpu_ack) begin
        chk("r27_data", 32'(bus.cpu_rdata), 32'(init_val(k)));
        k++;
        if (k < 4) cpu_issue(1'b0, AW'(k), '0);
        else       bus.cpu_req = 1'b0;
      end
    end
    chk("r27_acks", 32'(k), 32'd4);
    tick();

    // Simultaneous requests from idle
    acks_seen.delete();
    cpu_issue(1'b0, 16'h0030, '0);
    ldr_issue(1'b0, 16'h0031, '0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
      if (bus.ldr_ack) bus.ldr_req = 1'b0;
    end
    chk("r25_nacks", 32'(acks_seen.size()), 32'd2);
    chk("r25_first", 32'((acks_seen.size() > 0) ? acks_seen[0] : 1'b1), 32'd0);
    chk("r25_second", 32'((acks_seen.size() > 1) ? acks_seen[1] : 1'b0), 32'd1);

    // Continuous contention: 8 CPU grants then 1 loader grant
    acks_seen.delete();
    en_cnt = 0;
    cpu_issue(1'b0, AW'($urandom_range(0, 63)), '0);
    ldr_issue(1'b0, AW'($urandom_range(0, 63)), '0);
    for (int i = 0; i < 36; i++) begin
      tick();
      if (bus.cpu_ack) cpu_issue(1'b0, AW'($urandom_range(0, 63)), '0);
      if (bus.ldr_ack) ldr_issue(1'b0, AW'($urandom_range(0, 63)), '0);
    end
    chk("r24_nacks", 32'(acks_seen.size()), 32'd18);
    chk("r24_en_cnt", 32'(en_cnt), 32'd18);
    for (int i = 0; i < 18; i++) begin
      chk("r24_owner", 32'((acks_seen.size() > i) ? acks_seen[i] : 1'bx),
          32'((i % 9) == 8));
    end
    drain();

    // Reset during ISSUE of a CPU read
    cpu_issue(1'b0, 16'h0005, '0);
    tick();
    chk("r26_en_pre", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("r26_en", 32'(bus.mem_en), 32'd0);
    chk("r26_we", 32'(bus.mem_we), 32'd0);
    chk("r26_addr", 32'(bus.mem_addr), 32'd0);
    chk("r26_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("r26_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("r26_ldr_ack", 32'(bus.ldr_ack), 32'd0);
    chk("r26_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("r26_ldr_rdata", 32'(bus.ldr_rdata), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    tick();
    chk("r26_reissue_ack", 32'(bus.cpu_ack), 32'd1);
    chk("r26_reissue_data", 32'(bus.cpu_rdata), 32'(init_val(5)));
    bus.cpu_req = 1'b0;
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.cpu_ack || !bus.cpu_req) begin
        if ($urandom_range(0, 3) != 0)
          cpu_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom));
        else
          bus.cpu_req = 1'b0;
      end
      if (bus.ldr_ack || !bus.ldr_req) begin
        if ($urandom_range(0, 2) != 0)
          ldr_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom));
        else
          bus.ldr_req = 1'b0;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
